// File: rtl/dma_pkg.sv
// Shared types and constants for the single-channel DMA engine.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD2,
    REQ,
    RD,
    CAP,
    WR,
    DONE
  } dma_state_e;

  localparam logic DMA_MODE_COPY = 1'b1;
  localparam logic DMA_MODE_FILL = 1'b0;

endpackage

// File: rtl/dma_chan_regs.sv
// Channel register file for the DMA engine: source/destination pointers,
// remaining length, transfer mode and the one-word copy buffer.
module dma_chan_regs
  import dma_pkg::*;
#(
  parameter int SZ  = 8,
  parameter int WSZ = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_src,
  input  logic           load_dst,
  input  logic           capture,
  input  logic           step,
  input  logic [SZ-1:0]  cmd_addr,
  input  logic [WSZ-1:0] cmd_data,
  input  logic [WSZ-1:0] mem_rdata,
  output logic [SZ-1:0]  src,
  output logic [SZ-1:0]  dst,
  output logic           mode,
  output logic [WSZ-1:0] data_buf,
  output logic           len_zero,
  output logic           len_last
);

  logic [SZ-1:0] len;

  // Pointers wrap naturally at 2^SZ; phase 2 never coincides with a step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src      <= '0;
      dst      <= '0;
      len      <= '0;
      mode     <= DMA_MODE_FILL;
      data_buf <= '0;
    end else begin
      if (load_src) begin
        src <= cmd_addr;
        len <= cmd_data[SZ-1:0];
      end else if (step) begin
        src <= src + SZ'(1);
        len <= len - SZ'(1);
      end
      if (load_dst) begin
        dst  <= cmd_addr;
        mode <= cmd_data[0];
      end else if (step) begin
        dst <= dst + SZ'(1);
      end
      if (capture) begin
        data_buf <= mem_rdata;
      end
    end
  end

  assign len_zero = (len == '0);
  assign len_last = (len == SZ'(1));

endmodule

// File: rtl/dma_controller.sv
// Single-channel DMA responder: decodes the two-phase cpu command, copies or
// zero-fills a block over the shared bus. Optional cmd_err port: DMA_CMD_ERR_EN.
module dma_controller
  import dma_pkg::*;
#(
  parameter int SZ  = 8,
  parameter int WSZ = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_irq,
  input  logic [SZ-1:0]  cmd_addr,
  input  logic [WSZ-1:0] cmd_data,
  output logic           done_irq,
  output logic           bus_req,
  input  logic           bus_gnt,
  output logic [SZ-1:0]  mem_addr,
  output logic [WSZ-1:0] mem_wdata,
  output logic           mem_we,
  input  logic [WSZ-1:0] mem_rdata
`ifdef DMA_CMD_ERR_EN
  ,
  output logic           cmd_err
`endif
);

  dma_state_e     state, state_next;
  logic           load_src, load_dst, capture, step;
  logic [SZ-1:0]  src, dst;
  logic           mode;
  logic [WSZ-1:0] data_buf;
  logic           len_zero, len_last;

  dma_chan_regs #(.SZ(SZ), .WSZ(WSZ)) u_regs (
    .clk       (clk),
    .rst       (rst),
    .load_src  (load_src),
    .load_dst  (load_dst),
    .capture   (capture),
    .step      (step),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .mem_rdata (mem_rdata),
    .src       (src),
    .dst       (dst),
    .mode      (mode),
    .data_buf  (data_buf),
    .len_zero  (len_zero),
    .len_last  (len_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // WR re-checks the grant combinationally so a write can never coincide with a lost bus.
  always_comb begin
    state_next = state;
    load_src   = 1'b0;
    load_dst   = 1'b0;
    capture    = 1'b0;
    step       = 1'b0;
    bus_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (cmd_irq) begin
          load_src   = 1'b1;
          state_next = CMD2;
        end
      end
      CMD2: begin
        if (cmd_irq) begin
          load_dst   = 1'b1;
          state_next = REQ;
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        bus_req = 1'b1;
        if (len_zero)     state_next = DONE;
        else if (bus_gnt) state_next = (mode == DMA_MODE_COPY) ? RD : WR;
      end
      RD: begin
        bus_req    = 1'b1;
        mem_addr   = src;
        state_next = CAP;
      end
      CAP: begin
        bus_req    = 1'b1;
        capture    = 1'b1;
        state_next = bus_gnt ? WR : REQ;
      end
      WR: begin
        bus_req   = 1'b1;
        mem_addr  = dst;
        mem_wdata = (mode == DMA_MODE_COPY) ? data_buf : '0;
        if (bus_gnt) begin
          mem_we = 1'b1;
          step   = 1'b1;
          if (len_last) state_next = DONE;
          else          state_next = (mode == DMA_MODE_COPY) ? RD : WR;
        end else begin
          state_next = REQ;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done_irq is a level: set on the way into DONE, cleared only by the next phase 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          done_irq <= 1'b0;
    else if (state == IDLE && cmd_irq) done_irq <= 1'b0;
    else if (state_next == DONE)       done_irq <= 1'b1;
  end

`ifdef DMA_CMD_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         cmd_err <= 1'b0;
    else if (cmd_irq) cmd_err <= (state inside {REQ, RD, CAP, WR, DONE});
    else              cmd_err <= (state == CMD2);
  end
`endif

endmodule
